regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port (DA/D/W) of the 32x64 RegisterFile between two writeback requesters: requester 0 is ALU writeback, requester 1 is memory-load writeback.
- Each requester gets a one-entry holding slot with a valid/ready handshake.
- A round-robin arbiter drains the slots into a registered write strobe.
- Read-after-write hazard flags are provided for the two read-port selects (SA/SB).

Parameters:
- DATA_W, 64, data width of each register.
- ADDR_W, 5, register index width (32 registers).
- ZR_DISCARD, 1. When 1, writes to index 31 (XZR) are accepted and silently dropped, and never flag a hazard.

Ports:
- clock  in  1  rising-edge clock, shared with RegisterFile.
- reset  in  1  asynchronous, active-low reset; block is in reset while reset==0.
- req0_valid  in  1  ALU writeback request.
- req0_ready  out  1  slot 0 can accept this cycle.
- req0_addr  in  ADDR_W  destination register.
- req0_data  in  DATA_W  write data.
- req1_valid, req1_ready, req1_addr, req1_data: same as req0_*, for memory writeback.
- rd_sa  in  ADDR_W  read-port A select (mirrors SA).
- rd_sb  in  ADDR_W  read-port B select (mirrors SB).
- sa_hazard  out  1  a write to rd_sa is in flight.
- sb_hazard  out  1  a write to rd_sb is in flight.
- rf_w  out  1  to RegisterFile W.
- rf_da  out  ADDR_W  to RegisterFile DA.
- rf_d  out  DATA_W  to RegisterFile D.
- last_grant  out  1  requester granted most recently (debug/perf).

Behaviour:
- Reset (reset==0, asynchronous):
  - Both slots empty.
  - rf_w=0, rf_da=0, rf_d=0, last_grant=1, so requester 0 wins the first contention.
  - Priority pointer = 0.
  - Hazards read 0.
  - Asserting reset mid-operation discards held and in-flight writes; rf_w drops immediately.
- Slot i state: held_valid, held_addr, held_data.
- Ready and acceptance:
  - reqi_ready = !held_valid_i || grant_i.
  - Ready is combinational from slot state and arbitration only, never from reqi_valid.
  - Accept on rising edge when reqi_valid && reqi_ready.
  - If the slot is drained and refilled on the same edge, the new entry replaces the old one.
- Arbitration (combinational, each cycle):
  - Eligible = held_valid.
  - Neither eligible: no grant.
  - One eligible: grant it.
  - Both eligible: grant the priority pointer's side.
  - On any grant, the pointer moves to the other requester and last_grant = granted index.
- Output register, on the edge after a grant:
  - rf_w=1, rf_da=held_addr, rf_d=held_data.
  - The granted slot clears on the same edge unless it is refilled.
  - No grant: rf_w=0; rf_da and rf_d hold their values.
- Latency:
  - Accept at edge E0; rf_w high during the cycle after E1; RegisterFile captures at E2.
  - Uncontended minimum is 2 edges.
- Throughput: 1 write per cycle total; a single requester sustains 1 per cycle when the other is idle.
- XZR drop (ZR_DISCARD=1):
  - An entry with addr==31 still wins arbitration and frees its slot, but produces rf_w=0.
  - It consumes its grant and pointer rotation normally.
- Hazard:
  - sa_hazard = (held_valid0 && held_addr0==rd_sa) || (held_valid1 && held_addr1==rd_sa) || (rf_w && rf_da==rd_sa). sb_hazard is identical with rd_sb.
  - Both are forced to 0 when rd_sx==31 and ZR_DISCARD=1.
  - Hazards are combinational, with no internal bypass; the consumer stalls.
- Same address in both slots: both writes issue in arbitration order; the later grant's data ends in the register.

Decomposition:
- Package legv8_pkg holds DATA_W, ADDR_W and XZR_IDX=31, shared with RegisterFile and the decode logic.
- Sub-module wb_hold_slot implements one-entry storage plus the ready equation. It is instantiated twice.
- Arbiter, output register and hazard compare stay in the top module.

Test Plan:
- Reset values: hold reset=0 for 3 cycles, releasing at a non-edge time. Expect rf_w=0, rf_da=0, rf_d=0, req0_ready=req1_ready=1, sa_hazard=sb_hazard=0.
- Single write: req0 {addr=5, data=64'h1111} accepted at E0. Expect rf_w=1, rf_da=5, rf_d=64'h1111 for exactly one cycle after E1. sa_hazard=1 with rd_sa=5 from after E0 until rf_w falls.
- Contention: both requesters valid every cycle for 6 cycles with distinct addrs 1..12. Expect grants alternating 0,1,0,1,… on rf_da, and each ready low only while its slot is held and not granted.
- XZR: req1 {addr=31, data=64'hDEAD}. Expect req1_ready to recover, rf_w to stay 0, and sb_hazard=0 with rd_sb=31.
- Same destination: req0 {7, 64'hA} and req1 {7, 64'hB} accepted on the same edge, pointer=0. Expect rf_d=A then rf_d=B on consecutive cycles, and RegisterFile R07 finally equal to 64'hB.
- Mid-operation reset: assert reset=0 while both slots are held and rf_w=1. Expect rf_w to drop asynchronously, and no write to issue after release without new requests.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 register-file constants and writeback requester identifiers.
package legv8_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    // Index 31 is XZR: reads return zero and writes have no effect.
    localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // True when a register index names the zero register.
    function automatic logic is_xzr(input logic [ADDR_W-1:0] addr);
        return (addr == XZR_IDX);
    endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding slot with a valid/ready handshake.
// Ready depends only on slot occupancy and the arbiter grant, never on req_valid.
module wb_hold_slot #(
    parameter int DATA_W = legv8_pkg::DATA_W,
    parameter int ADDR_W = legv8_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              grant,
    output logic              req_ready,
    output logic              held_valid,
    output logic [ADDR_W-1:0] held_addr,
    output logic [DATA_W-1:0] held_data
);

    logic              ready_s;
    logic              valid_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;

    // The slot can take a new entry when empty or when its entry leaves this cycle.
    always_comb begin
        ready_s = (!valid_r) || grant;
    end

    // Load on handshake (a refill overrides a simultaneous drain), else clear on grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
        end else if (req_valid && ready_s) begin
            valid_r <= 1'b1;
            addr_r  <= req_addr;
            data_r  <= req_data;
        end else if (grant) begin
            valid_r <= 1'b0;
        end
    end

    assign req_ready  = ready_s;
    assign held_valid = valid_r;
    assign held_addr  = addr_r;
    assign held_data  = data_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the RegisterFile write port between ALU and
// memory-load writeback, with read-after-write hazard flags for SA/SB.
module regfile_wb_arbiter #(
    parameter int DATA_W     = legv8_pkg::DATA_W,
    parameter int ADDR_W     = legv8_pkg::ADDR_W,
    parameter bit ZR_DISCARD = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [ADDR_W-1:0] rd_sa,
    input  logic [ADDR_W-1:0] rd_sb,
    output logic              sa_hazard,
    output logic              sb_hazard,
    output logic              rf_w,
    output logic [ADDR_W-1:0] rf_da,
    output logic [DATA_W-1:0] rf_d,
    output logic              last_grant
);

    import legv8_pkg::XZR_IDX;

    logic              held_valid0_s, held_valid1_s;
    logic [ADDR_W-1:0] held_addr0_s, held_addr1_s;
    logic [DATA_W-1:0] held_data0_s, held_data1_s;
    logic              grant0_s, grant1_s, any_grant_s, drop_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sa_hazard_s, sb_hazard_s;
    logic              ptr_r, last_grant_r, rf_w_r;
    logic [ADDR_W-1:0] rf_da_r;
    logic [DATA_W-1:0] rf_d_r;

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
        .clock(clock), .reset(reset),
        .req_valid(req0_valid), .req_addr(req0_addr), .req_data(req0_data),
        .grant(grant0_s), .req_ready(req0_ready),
        .held_valid(held_valid0_s), .held_addr(held_addr0_s), .held_data(held_data0_s)
    );

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
        .clock(clock), .reset(reset),
        .req_valid(req1_valid), .req_addr(req1_addr), .req_data(req1_data),
        .grant(grant1_s), .req_ready(req1_ready),
        .held_valid(held_valid1_s), .held_addr(held_addr1_s), .held_data(held_data1_s)
    );

    // Grant the only occupied slot, or the pointer's side when both are occupied.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case ({held_valid1_s, held_valid0_s})
            2'b01: grant0_s = 1'b1;
            2'b10: grant1_s = 1'b1;
            2'b11: begin
                if (ptr_r == 1'b0) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
    end

    // Mux the winning entry; an XZR entry is still granted but produces no write.
    always_comb begin
        any_grant_s = grant0_s || grant1_s;
        if (grant1_s) begin
            sel_addr_s = held_addr1_s;
            sel_data_s = held_data1_s;
        end else begin
            sel_addr_s = held_addr0_s;
            sel_data_s = held_data0_s;
        end
        drop_s = ZR_DISCARD && (sel_addr_s == XZR_IDX);
    end

    // Write strobe register and round-robin bookkeeping; address/data hold when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_w_r       <= 1'b0;
            rf_da_r      <= {ADDR_W{1'b0}};
            rf_d_r       <= {DATA_W{1'b0}};
            ptr_r        <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (any_grant_s) begin
            rf_w_r       <= !drop_s;
            ptr_r        <= grant0_s;
            last_grant_r <= grant1_s;
            if (!drop_s) begin
                rf_da_r <= sel_addr_s;
                rf_d_r  <= sel_data_s;
            end
        end else begin
            rf_w_r <= 1'b0;
        end
    end

    // A read select is hazardous while any held or issuing write targets it (never XZR).
    always_comb begin
        sa_hazard_s = (held_valid0_s && (held_addr0_s == rd_sa)) ||
                      (held_valid1_s && (held_addr1_s == rd_sa)) ||
                      (rf_w_r && (rf_da_r == rd_sa));
        sb_hazard_s = (held_valid0_s && (held_addr0_s == rd_sb)) ||
                      (held_valid1_s && (held_addr1_s == rd_sb)) ||
                      (rf_w_r && (rf_da_r == rd_sb));
        if (ZR_DISCARD && (rd_sa == XZR_IDX)) begin
            sa_hazard_s = 1'b0;
        end else begin
            sa_hazard_s = sa_hazard_s;
        end
        if (ZR_DISCARD && (rd_sb == XZR_IDX)) begin
            sb_hazard_s = 1'b0;
        end else begin
            sb_hazard_s = sb_hazard_s;
        end
    end

    assign sa_hazard  = sa_hazard_s;
    assign sb_hazard  = sb_hazard_s;
    assign rf_w       = rf_w_r;
    assign rf_da      = rf_da_r;
    assign rf_d       = rf_d_r;
    assign last_grant = last_grant_r;

endmodule
